// File: rtl/sd_dac_modulator_if.sv
// Sample handshake and modulator output bundle for sd_dac_modulator.
// The master side feeds samples; the slave side is the modulator.
interface sd_dac_modulator_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     bit_out;
  logic                     sample_tick;
  logic                     underrun;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  bit_out,
    input  sample_tick,
    input  underrun
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output bit_out,
    output sample_tick,
    output underrun
  );
endinterface

// File: rtl/sd_dac_modulator.sv
// Sigma-delta DAC modulator: one pending slot, OSR-clock sample hold, 1-bit output.
// Define SD_DAC_SECOND_ORDER_EN for the second-order CIFB loop; default is first-order.
module sd_dac_modulator #(
  parameter int DATA_W = 16,
  parameter int OSR    = 64,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  sd_dac_modulator_if.slave dac_if
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              bit_out_q, bit_out_d;
  logic              tick_q, tick_d;
  logic              underrun_q, underrun_d;
  logic              boundary_s;
  logic              accept_s;

  assign boundary_s = (cnt_q == CNT_LAST);
  assign accept_s   = dac_if.din_valid & ~pend_full_q;

  // Counter, pending slot and active-sample hand-over.
  always_comb begin
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    tick_d      = 1'b0;
    underrun_d  = 1'b0;
    if (boundary_s) begin
      cnt_d  = {CNT_W{1'b0}};
      tick_d = 1'b1;
      if (pend_full_q) begin
        active_d    = pend_q;
        pend_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // An empty slot at a boundary still takes the new sample; it is never bypassed to active.
    if (accept_s) begin
      pend_d      = dac_if.din;
      pend_full_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

`ifdef SD_DAC_SECOND_ORDER_EN
  localparam int IW = DATA_W + 4;
  localparam int EW = DATA_W + 6;
  localparam logic signed [EW-1:0] SAT_HI = EW'(32'sd1 <<< (DATA_W + 2));
  localparam logic signed [EW-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [EW-1:0] FB_MAG = EW'(32'sd1 <<< (DATA_W - 1));

  logic signed [IW-1:0] i1_q, i1_d;
  logic signed [IW-1:0] i2_q, i2_d;
  logic signed [EW-1:0] x_s, fb_s, i1_sum_s, i2_sum_s;

  function automatic logic signed [IW-1:0] sat_int(input logic signed [EW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > SAT_HI) begin
      r = IW'(SAT_HI);
    end else if (v < SAT_LO) begin
      r = IW'(SAT_LO);
    end else begin
      r = IW'(v);
    end
    return r;
  endfunction

  // Two saturating integrators; sums are formed two bits wider so clamping never sees a wrap.
  always_comb begin
    x_s       = EW'($signed(active_q));
    fb_s      = bit_out_q ? FB_MAG : -FB_MAG;
    i1_sum_s  = EW'(i1_q) + x_s - fb_s;
    i1_d      = sat_int(i1_sum_s);
    i2_sum_s  = EW'(i2_q) + EW'(i1_d) - fb_s;
    i2_d      = sat_int(i2_sum_s);
    bit_out_d = ~i2_d[IW-1];
  end

  // Integrator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_q <= {IW{1'b0}};
      i2_q <= {IW{1'b0}};
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
    end
  end
`else
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] u_s;
  logic [DATA_W:0]   sum_s;

  // Offset-binary error feedback: the accumulator carry is the output bit.
  always_comb begin
    u_s       = {~active_q[DATA_W-1], active_q[DATA_W-2:0]};
    sum_s     = {1'b0, acc_q} + {1'b0, u_s};
    bit_out_d = sum_s[DATA_W];
    acc_d     = sum_s[DATA_W-1:0];
  end

  // Accumulator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= {DATA_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= {CNT_W{1'b0}};
      pend_q      <= {DATA_W{1'b0}};
      pend_full_q <= 1'b0;
      active_q    <= {DATA_W{1'b0}};
      bit_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      bit_out_q   <= bit_out_d;
      tick_q      <= tick_d;
      underrun_q  <= underrun_d;
    end
  end

  assign dac_if.din_ready   = ~pend_full_q;
  assign dac_if.bit_out     = bit_out_q;
  assign dac_if.sample_tick = tick_q;
  assign dac_if.underrun    = underrun_q;

endmodule

// File: tb/tb_sd_dac_modulator.sv
// Directed bench for sd_dac_modulator (first-order build, DATA_W=16, OSR=8).
// Edge numbering: edge 1 is the first rising clock after reset release.
module tb_sd_dac_modulator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sd_dac_modulator_if #(.DATA_W(16)) dac_if ();

  sd_dac_modulator #(
    .DATA_W(16),
    .OSR   (8),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dac_if(dac_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    dac_if.din       = 16'h0000;
    dac_if.din_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    dac_if.din       = 16'h0000;
    dac_if.din_valid = 1'b0;
    #2;
    checks++;
    if ({dac_if.bit_out, dac_if.sample_tick, dac_if.underrun, dac_if.din_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0001",
               {dac_if.bit_out, dac_if.sample_tick, dac_if.underrun, dac_if.din_ready});
    end
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({dac_if.bit_out, dac_if.sample_tick, dac_if.underrun, dac_if.din_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0001",
               {dac_if.bit_out, dac_if.sample_tick, dac_if.underrun, dac_if.din_ready});
    end
  endtask

  task automatic test_midscale();
    int ones;
    int bad_edge;
    int bad_tick;
    do_reset();
    dac_if.din       = 16'h0000;
    dac_if.din_valid = 1'b1;
    ones     = 0;
    bad_edge = 0;
    bad_tick = 0;
    for (int e = 1; e <= 256; e++) begin
      step();
      if (dac_if.bit_out === 1'b1) ones++;
      if (bad_edge == 0 && dac_if.bit_out !== ((e % 2) == 0)) bad_edge = e;
      if (bad_tick == 0 && dac_if.sample_tick !== ((e % 8) == 0)) bad_tick = e;
    end
    dac_if.din_valid = 1'b0;
    checks++;
    if (ones !== 128) begin
      errors++;
      $display("FAIL midscale_ones: got %0d expected 128", ones);
    end
    checks++;
    if (bad_edge !== 0) begin
      errors++;
      $display("FAIL midscale_pattern: first wrong edge %0d expected none", bad_edge);
    end
    checks++;
    if (bad_tick !== 0) begin
      errors++;
      $display("FAIL midscale_tick: first wrong edge %0d expected none", bad_tick);
    end
  endtask

  task automatic test_full_scale();
    int ones;
    logic first_bit;
    // Negative full scale: u = 0, no ones once active.
    do_reset();
    dac_if.din       = 16'h8000;
    dac_if.din_valid = 1'b1;
    step();
    dac_if.din_valid = 1'b0;
    for (int e = 2; e <= 8; e++) step();
    ones = 0;
    for (int e = 9; e <= 1032; e++) begin
      step();
      if (dac_if.bit_out === 1'b1) ones++;
    end
    checks++;
    if (ones !== 0) begin
      errors++;
      $display("FAIL fullscale_neg_ones: got %0d expected 0", ones);
    end
    // Positive full scale: accumulator is 0 at the boundary, first bit 0, then ones.
    do_reset();
    dac_if.din       = 16'h7FFF;
    dac_if.din_valid = 1'b1;
    step();
    dac_if.din_valid = 1'b0;
    for (int e = 2; e <= 8; e++) step();
    ones      = 0;
    first_bit = 1'bx;
    for (int e = 9; e <= 1032; e++) begin
      step();
      if (e == 9) first_bit = dac_if.bit_out;
      if (dac_if.bit_out === 1'b1) ones++;
    end
    checks++;
    if (ones !== 1023) begin
      errors++;
      $display("FAIL fullscale_pos_ones: got %0d expected 1023", ones);
    end
    checks++;
    if (first_bit !== 1'b0) begin
      errors++;
      $display("FAIL fullscale_pos_first: got %b expected 0", first_bit);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:23] got_bits, got_ready, got_tick, got_under;
    logic [0:23] exp_bits, exp_ready, exp_tick, exp_under;
    exp_bits  = 24'b01010101_01010101_10110101;
    exp_ready = 24'b00000001_00000001_11111111;
    exp_tick  = 24'b00000001_00000001_00000001;
    exp_under = 24'b00000000_00000000_00000001;
    do_reset();
    dac_if.din       = 16'h1000;
    dac_if.din_valid = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      got_bits[e-1]  = dac_if.bit_out;
      got_ready[e-1] = dac_if.din_ready;
      got_tick[e-1]  = dac_if.sample_tick;
      got_under[e-1] = dac_if.underrun;
      if (e == 1) dac_if.din = 16'h2000;
      if (e == 9) dac_if.din_valid = 1'b0;
    end
    checks++;
    if (got_bits !== exp_bits) begin
      errors++;
      $display("FAIL b2b_bits: got %b expected %b", got_bits, exp_bits);
    end
    checks++;
    if (got_ready !== exp_ready) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected %b", got_ready, exp_ready);
    end
    checks++;
    if (got_tick !== exp_tick) begin
      errors++;
      $display("FAIL b2b_tick: got %b expected %b", got_tick, exp_tick);
    end
    checks++;
    if (got_under !== exp_under) begin
      errors++;
      $display("FAIL b2b_underrun: got %b expected %b", got_under, exp_under);
    end
  endtask

  task automatic test_underrun();
    logic [0:31] got_bits, got_ready, got_tick, got_under;
    logic [0:31] exp_bits, exp_ready, exp_tick, exp_under;
    exp_bits  = 32'b01010101_01110111_01110111_01010101;
    exp_ready = 32'b00000001_11111110_00000001_11111111;
    exp_tick  = 32'b00000001_00000001_00000001_00000001;
    exp_under = 32'b00000000_00000001_00000000_00000001;
    do_reset();
    dac_if.din       = 16'h4000;
    dac_if.din_valid = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      got_bits[e-1]  = dac_if.bit_out;
      got_ready[e-1] = dac_if.din_ready;
      got_tick[e-1]  = dac_if.sample_tick;
      got_under[e-1] = dac_if.underrun;
      if (e == 1) dac_if.din_valid = 1'b0;
      if (e == 15) begin
        dac_if.din       = 16'h0000;
        dac_if.din_valid = 1'b1;
      end
      if (e == 16) dac_if.din_valid = 1'b0;
    end
    checks++;
    if (got_bits !== exp_bits) begin
      errors++;
      $display("FAIL underrun_bits: got %b expected %b", got_bits, exp_bits);
    end
    checks++;
    if (got_ready !== exp_ready) begin
      errors++;
      $display("FAIL underrun_ready: got %b expected %b", got_ready, exp_ready);
    end
    checks++;
    if (got_tick !== exp_tick) begin
      errors++;
      $display("FAIL underrun_tick: got %b expected %b", got_tick, exp_tick);
    end
    checks++;
    if (got_under !== exp_under) begin
      errors++;
      $display("FAIL underrun_pulse: got %b expected %b", got_under, exp_under);
    end
  endtask

  task automatic test_reset_midstream();
    logic [0:7] got_bits, got_tick, got_under;
    logic [0:7] exp_bits, exp_tick, exp_under;
    exp_bits  = 8'b01010101;
    exp_tick  = 8'b00000001;
    exp_under = 8'b00000001;
    do_reset();
    dac_if.din       = 16'h1000;
    dac_if.din_valid = 1'b1;
    step();
    dac_if.din_valid = 1'b0;
    step();
    checks++;
    if ({dac_if.bit_out, dac_if.din_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_pre: got %b expected 10", {dac_if.bit_out, dac_if.din_ready});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dac_if.bit_out, dac_if.underrun, dac_if.sample_tick, dac_if.din_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_async: got %b expected 0001",
               {dac_if.bit_out, dac_if.underrun, dac_if.sample_tick, dac_if.din_ready});
    end
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      got_bits[e-1]  = dac_if.bit_out;
      got_tick[e-1]  = dac_if.sample_tick;
      got_under[e-1] = dac_if.underrun;
    end
    checks++;
    if (got_bits !== exp_bits) begin
      errors++;
      $display("FAIL midreset_bits: got %b expected %b", got_bits, exp_bits);
    end
    checks++;
    if (got_tick !== exp_tick) begin
      errors++;
      $display("FAIL midreset_tick: got %b expected %b", got_tick, exp_tick);
    end
    checks++;
    if (got_under !== exp_under) begin
      errors++;
      $display("FAIL midreset_underrun: got %b expected %b", got_under, exp_under);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_midscale();
    test_full_scale();
    test_back_to_back();
    test_underrun();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
